regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 8 x 16-bit LC-3 register file (one write port, LD_REG + 3-bit DR select).
- Arbitrates two write-back requesters (req 0 = ALU, req 1 = MEM load) onto the single write port through a registered output stage.
- Tracks in-flight destination registers so issue logic stalls on RAW/WAW hazards.
- Sits between the control FSM/issue logic and the register file.

Parameters:
- DATA_W, 16, register data width
- NREG, 8, number of architectural registers
- REG_AW, 3, register index width (log2 NREG)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester write-back request (bit 0 ALU, bit 1 MEM)
- req_dr  in  2xREG_AW  per-requester destination register
- req_data  in  2xDATA_W  per-requester write data
- req_ready  out  2  per-requester acceptance (grant)
- iss_valid  in  1  issue logic presents an instruction
- iss_dr  in  REG_AW  destination of issuing instruction
- iss_sr1  in  REG_AW  source 1
- iss_sr2  in  REG_AW  source 2
- iss_use_sr2  in  1  instruction reads SR2 (register-mode operand)
- iss_has_dr  in  1  instruction writes a register
- iss_stall  out  1  hazard; issue must hold
- wb_load  out  1  to register file LD_REG
- wb_dr  out  REG_AW  to register file DRMUX
- wb_data  out  DATA_W  to register file Data
- busy  out  NREG  scoreboard bits
- err_spurious  out  1  sticky: write-back to a non-busy register

Behaviour:
- Reset (synchronous, Reset=1 at rising Clk): wb_load=0, wb_dr=0, wb_data=0, busy=0, err_spurious=0, RR pointer selects req 0 first. A pending request is dropped; the requester must hold valid, and ready is 0 while Reset=1.
- Arbitration (combinational): req_ready[i]=1 only for the granted requester, and only when req_valid[i]=1. At most one grant per cycle. Default is fixed priority, req 0 over req 1.
- Transfer: occurs when req_valid[i] & req_ready[i]. Next cycle wb_load=1, wb_dr=req_dr[i], wb_data=req_data[i]. Latency is exactly 1 cycle. wb_load is a single-cycle pulse per transfer. Back-to-back transfers give wb_load high on consecutive cycles.
- No transfer: wb_load=0 next cycle. wb_dr and wb_data hold their last values.
- Scoreboard set: when iss_valid & ~iss_stall & iss_has_dr, busy[iss_dr] is set next cycle.
- Scoreboard clear: busy[wb_dr] is cleared on the edge where wb_load=1, so the bit is already 0 in the cycle after the register file captures the data.
- Same index set and cleared in the same edge: set wins.
- Spurious write-back: wb_load=1 with busy[wb_dr]=0 sets err_spurious. The data is still written. err_spurious stays set until Reset.
- iss_stall (combinational) = iss_valid & (busy[iss_sr1] | (iss_use_sr2 & busy[iss_sr2]) | (iss_has_dr & busy[iss_dr])).
- No forwarding: a source waits until the cycle after its wb_load pulse.
- SR1 == SR2 == DR on one register: evaluated once, no special case.

Optional Feature:
- Macro: REGFILE_WB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer toggles to favour the requester not granted last. When both are valid, grants alternate. A single valid requester is always granted and the pointer updates to it.
- Undefined: fixed priority, ALU (req 0) always wins; MEM can starve.

Decomposition:
- Shared package regfile_pkg: DATA_W, NREG, REG_AW constants; a typedef for the register index; a typedef struct wb_req_t {dr, data}.
- Sub-module wb_arbiter: 2-input arbiter with pointer register and REGFILE_WB_RR_EN handling.
- Scoreboard and output stage stay in the top level.

Test Plan:
- Reset mid-transfer: request accepted, Reset asserted the next cycle -> wb_load=0, busy=0, err_spurious=0 after the edge, and req_ready=0 while Reset=1.
- Single write: issue dr=R3 (busy[3]=1), then ALU req dr=3 data=16'h1234 -> req_ready[0]=1; next cycle wb_load=1, wb_dr=3, wb_data=16'h1234; the cycle after, busy[3]=0.
- RAW stall: busy[5]=1, iss_sr1=5 -> iss_stall=1 until the cycle after the R5 wb_load pulse; iss_use_sr2=0 with iss_sr2=5 and other regs free -> no stall on SR2.
- Contention: both valid, ALU dr=1 data=16'hAAAA, MEM dr=2 data=16'h5555, held 4 cycles.
  - Fixed priority -> ALU granted all 4 cycles.
  - REGFILE_WB_RR_EN -> grants ALU, MEM, ALU, MEM; wb_dr sequence 1,2,1,2.
- WAW: busy[7]=1, issue with iss_dr=7, iss_has_dr=1 -> iss_stall=1; the same issue with iss_has_dr=0 and non-busy sources -> iss_stall=0.
- Spurious write: busy=0, MEM req dr=4 data=16'hBEEF -> wb_load pulse writes it and err_spurious=1 stays high until Reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LC-3 register-file write-back scheduler.
package regfile_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 8;
   localparam int unsigned REG_AW = 3;

   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          dr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-input write-back arbiter: fixed priority (req 0 wins) by default, round-robin when
// REGFILE_WB_RR_EN is defined.
module wb_arbiter (
`ifdef REGFILE_WB_RR_EN
   input  logic       clk,
   input  logic       reset,
`endif
   input  logic [1:0] req_valid,
   output logic [1:0] grant
);

`ifdef REGFILE_WB_RR_EN
   // ptr_q names the requester favoured when both are valid.
   logic ptr_q, ptr_d;

   always_comb begin
      grant = 2'b00;
      ptr_d = ptr_q;
      if (req_valid == 2'b11) begin
         grant[ptr_q] = 1'b1;
      end else begin
         grant = req_valid;
      end
      if (grant[0]) begin
         ptr_d = 1'b1;
      end else if (grant[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      grant    = 2'b00;
      grant[0] = req_valid[0];
      grant[1] = req_valid[1] & ~req_valid[0];
   end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the LC-3 8x16 register file.
// Optional round-robin arbitration via REGFILE_WB_RR_EN.
module regfile_wb_sched
   import regfile_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            req_valid,
   input  logic [2*REG_AW-1:0]   req_dr,
   input  logic [2*DATA_W-1:0]   req_data,
   output logic [1:0]            req_ready,
   input  logic                  iss_valid,
   input  logic [REG_AW-1:0]     iss_dr,
   input  logic [REG_AW-1:0]     iss_sr1,
   input  logic [REG_AW-1:0]     iss_sr2,
   input  logic                  iss_use_sr2,
   input  logic                  iss_has_dr,
   output logic                  iss_stall,
   output logic                  wb_load,
   output logic [REG_AW-1:0]     wb_dr,
   output logic [DATA_W-1:0]     wb_data,
   output logic [NREG-1:0]       busy,
   output logic                  err_spurious
);

   wb_req_t           req [2];
   logic [1:0]        grant;
   logic              xfer;
   logic              sel;

   logic              wb_load_q, wb_load_d;
   reg_idx_t          wb_dr_q, wb_dr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              err_q, err_d;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         req[i].dr   = req_dr[i*REG_AW +: REG_AW];
         req[i].data = req_data[i*DATA_W +: DATA_W];
      end
   end

   wb_arbiter u_arb (
`ifdef REGFILE_WB_RR_EN
      .clk       (Clk),
      .reset     (Reset),
`endif
      .req_valid (req_valid),
      .grant     (grant)
   );

   // Nothing is accepted while Reset is high; the requester keeps valid asserted.
   assign req_ready = Reset ? 2'b00 : grant;

   assign iss_stall = iss_valid & (busy_q[iss_sr1] | (iss_use_sr2 & busy_q[iss_sr2]) |
                                   (iss_has_dr & busy_q[iss_dr]));

   always_comb begin
      xfer      = |req_ready;
      sel       = req_ready[1];
      wb_load_d = xfer;
      wb_dr_d   = wb_dr_q;
      wb_data_d = wb_data_q;
      if (xfer) begin
         wb_dr_d   = req[sel].dr;
         wb_data_d = req[sel].data;
      end

      // Clear first so a same-edge set on the same index wins.
      busy_d = busy_q;
      if (wb_load_q) begin
         busy_d[wb_dr_q] = 1'b0;
      end
      if (iss_valid && !iss_stall && iss_has_dr) begin
         busy_d[iss_dr] = 1'b1;
      end

      err_d = err_q | (wb_load_q & ~busy_q[wb_dr_q]);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wb_load_q <= 1'b0;
         wb_dr_q   <= '0;
         wb_data_q <= '0;
         busy_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         wb_load_q <= wb_load_d;
         wb_dr_q   <= wb_dr_d;
         wb_data_q <= wb_data_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign wb_load      = wb_load_q;
   assign wb_dr        = wb_dr_q;
   assign wb_data      = wb_data_q;
   assign busy         = busy_q;
   assign err_spurious = err_q;

endmodule
